sha256_mem_arbiter: RTL and testbench
=====================================

# sha256_mem_arbiter

Shares the single word-addressed message/output memory port between `NUM_CORES` SHA-256 hash cores in the Bitcoin hasher. Each core issues one read or write per request. The arbiter grants one request per cycle using round-robin priority with a bounded burst, so a core streaming sequential message words keeps the port. It drives the memory port through registers and routes read data back to the requester with a tagged valid.

## Interface
- `NUM_CORES`, default 4: number of requesting cores (2..8).
- `MAX_BURST`, default 16: maximum consecutive grants to one core while other cores are requesting.
- `clk`  in  1  single clock for the arbiter and memory.
- `reset_n`  in  1  reset, synchronous and active-low.
- `req`  in  NUM_CORES  core i requests an access; held until granted.
- `we`  in  NUM_CORES  core i access is a write when 1, a read when 0.
- `addr`  in  16*NUM_CORES  core i address at bits [16*i +: 16].
- `wdata`  in  32*NUM_CORES  core i write data at bits [32*i +: 32].
- `gnt`  out  NUM_CORES  one-hot, combinational: core i request accepted this cycle.
- `rvalid`  out  NUM_CORES  one-hot, registered: read data for core i is on `rdata`.
- `rdata`  out  32  equal to `mem_read_data`, shared by all cores.
- `mem_we`  out  1  registered memory write enable.
- `mem_addr`  out  16  registered memory address.
- `mem_write_data`  out  32  registered memory write data.
- `mem_read_data`  in  32  memory read data, valid one cycle after its address.

## Operation
- Core rule: `addr`/`we`/`wdata` stay stable while `req`=1 and `gnt`=0. The core may drop `req` or present a new access in the cycle after it is granted.
- State registers: `state` {IDLE, BURST}, `owner` (core index), `burst_cnt` (0..MAX_BURST), `rr_ptr` (core index).
- IDLE:
  - If any `req` is set, grant the first requester searching circularly from `rr_ptr`.
  - Then `owner`<=granted core, `burst_cnt`<=1, `state`<=BURST.
  - Otherwise no grant.
- BURST:
  - If `req[owner]`=1 and either `burst_cnt`<MAX_BURST or no other core requests: grant `owner`. `burst_cnt` increments and saturates at MAX_BURST.
  - Else if any other core requests: grant the first requester searching circularly from `owner`+1. `owner`<=that core, `burst_cnt`<=1.
  - Else: no grant, `state`<=IDLE, `rr_ptr`<=`owner`+1 mod NUM_CORES.
- Exactly one grant per cycle at most; `gnt` is one-hot or zero.
- Granted access: `mem_addr`, `mem_we`, `mem_write_data` load from the granted core's fields.
- Cycle without a grant: `mem_we`<=0; `mem_addr` and `mem_write_data` hold their previous values.
- Tag pipeline: a granted read pushes a one-hot tag through 2 register stages that drive `rvalid`. Writes produce no `rvalid`.
- Width: all core indices wrap modulo NUM_CORES. `burst_cnt` is $clog2(MAX_BURST+1) bits.

## Timing
- Reset: on a clock edge with `reset_n`=0, the block clears:
  - `state`=IDLE, `owner`=0, `burst_cnt`=0, `rr_ptr`=0;
  - `mem_we`=0, `mem_addr`=0, `mem_write_data`=0;
  - `rvalid`=0 and both tag stages.
- While `reset_n`=0, `gnt` is forced to 0.
- Reads in flight at reset are discarded; no `rvalid` is issued for them.
- Latency, with the grant in cycle T:
  - memory port driven in T+1;
  - `rvalid[i]`=1 with `rdata` valid in T+2.
- Throughput: one access per cycle, with no bubble between back-to-back grants, including owner switches.
- A write in T followed by a read of the same address in T+1 returns the new data, since the memory handles writes in order.
- Simultaneous events:
  - Owner drops `req` in the same cycle another core raises `req`: the other core is granted that cycle, with no IDLE cycle.
  - `burst_cnt`=MAX_BURST with only the owner requesting: the owner keeps the grant.

## Test plan
- Core 0 alone reads 0x0010–0x0013 (memory holds 0xA0..0xA3), `req` held 4 cycles from T. Expect `gnt[0]`=1 for T..T+3, `mem_addr`=0x0010..0x0013 over T+1..T+4, and `rvalid[0]` with `rdata`=0xA0..0xA3 over T+2..T+5.
- All 4 cores request reads continuously with MAX_BURST=16. Expect exactly 16 grants each in order 0,1,2,3,0, switching with no idle cycle, and `rvalid` tags matching the grants 2 cycles later.
- Core 2 writes 0xDEADBEEF to 0x0100, then core 1 reads 0x0100. Expect `mem_we`=1 for exactly one cycle, no `rvalid[2]`, and `rvalid[1]` with `rdata`=0xDEADBEEF.
- Core 1 owns the port and releases `req`. One cycle later, cores 0 and 2 request in the same cycle. Expect the arbiter goes IDLE with `rr_ptr`=2, and core 2 is granted first, then core 0.
- Assert `reset_n`=0 for one cycle mid-burst, with two reads in flight. Expect next cycle `rvalid`=0, `mem_we`=0, `mem_addr`=0 and no stale `rvalid` afterwards. With all cores requesting after release, core 0 is granted first.
- No requests for 10 cycles. Expect `gnt`=0, `mem_we`=0, `rvalid`=0, and `mem_addr` holding its last value.

Source files
------------

// File: rtl/sha256_mem_arbiter.sv
// sha256_mem_arbiter
// Shares one word-addressed memory port between NUM_CORES SHA-256 cores.
// Round-robin arbitration with a bounded burst: the current owner keeps the
// port for up to MAX_BURST consecutive grants while others wait, and without
// limit when nobody else is asking. The memory port is driven from registers
// and read data is returned with a one-hot tag two cycles after the grant.
module sha256_mem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CORES-1:0]    req,
    input  logic [NUM_CORES-1:0]    we,
    input  logic [16*NUM_CORES-1:0] addr,
    input  logic [32*NUM_CORES-1:0] wdata,
    output logic [NUM_CORES-1:0]    gnt,
    output logic [NUM_CORES-1:0]    rvalid,
    output logic [31:0]             rdata,
    output logic                    mem_we,
    output logic [15:0]             mem_addr,
    output logic [31:0]             mem_write_data,
    input  logic [31:0]             mem_read_data
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Core index -> one-hot core mask.
    function automatic logic [NUM_CORES-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_CORES-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            oh[i] = (IDX_W'(i) == idx);
        end
        return oh;
    endfunction

    // Core index + 1, wrapping at NUM_CORES (not necessarily a power of two).
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] nxt;
        nxt = (idx == IDX_W'(NUM_CORES - 1)) ? '0 : (idx + IDX_W'(1));
        return nxt;
    endfunction

    // First set bit of mask searching circularly from start.
    // Returns {found, index}.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_CORES-1:0] mask,
                                                input logic [IDX_W-1:0]     start);
        logic             found;
        logic             hit;
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        pick  = start;
        cand  = start;
        for (int i = 0; i < NUM_CORES; i++) begin
            hit   = !found && mask[cand];
            pick  = hit ? cand : pick;
            found = found | hit;
            cand  = idx_inc(cand);
        end
        return {found, pick};
    endfunction

    arb_state_t             state_r;
    arb_state_t             state_nxt_s;
    logic [IDX_W-1:0]       owner_r;
    logic [IDX_W-1:0]       owner_nxt_s;
    logic [CNT_W-1:0]       burst_cnt_r;
    logic [CNT_W-1:0]       burst_cnt_nxt_s;
    logic [IDX_W-1:0]       rr_ptr_r;
    logic [IDX_W-1:0]       rr_ptr_nxt_s;

    logic                   grant_vld_s;
    logic [IDX_W-1:0]       grant_idx_s;
    logic [NUM_CORES-1:0]   gnt_s;
    logic [NUM_CORES-1:0]   owner_oh_s;
    logic [NUM_CORES-1:0]   others_s;
    logic                   owner_req_s;
    logic [IDX_W:0]         idle_pick_s;
    logic [IDX_W:0]         switch_pick_s;

    logic [NUM_CORES-1:0]   sel_oh_s;
    logic                   sel_we_s;
    logic [15:0]            sel_addr_s;
    logic [31:0]            sel_wdata_s;

    logic                   mem_we_r;
    logic [15:0]            mem_addr_r;
    logic [31:0]            mem_write_data_r;
    logic [NUM_CORES-1:0]   tag1_r;
    logic [NUM_CORES-1:0]   tag2_r;

    assign owner_oh_s    = idx_to_onehot(owner_r);
    assign others_s      = req & ~owner_oh_s;
    assign owner_req_s   = |(req & owner_oh_s);
    assign idle_pick_s   = rr_pick(req, rr_ptr_r);
    assign switch_pick_s = rr_pick(others_s, idx_inc(owner_r));

    // Arbiter state register: state, owner, burst length and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            owner_r     <= '0;
            burst_cnt_r <= '0;
            rr_ptr_r    <= '0;
        end else begin
            state_r     <= state_nxt_s;
            owner_r     <= owner_nxt_s;
            burst_cnt_r <= burst_cnt_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
        end
    end

    // Next-state and grant decision: idle pick, burst continuation or owner switch.
    always_comb begin
        state_nxt_s     = state_r;
        owner_nxt_s     = owner_r;
        burst_cnt_nxt_s = burst_cnt_r;
        rr_ptr_nxt_s    = rr_ptr_r;
        grant_vld_s     = 1'b0;
        grant_idx_s     = owner_r;
        case (state_r)
            ST_IDLE: begin
                if (idle_pick_s[IDX_W]) begin
                    grant_vld_s     = 1'b1;
                    grant_idx_s     = idle_pick_s[IDX_W-1:0];
                    owner_nxt_s     = idle_pick_s[IDX_W-1:0];
                    burst_cnt_nxt_s = CNT_ONE;
                    state_nxt_s     = ST_BURST;
                end else begin
                    state_nxt_s     = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (owner_req_s && ((burst_cnt_r < CNT_MAX) || !(|others_s))) begin
                    // Owner keeps the port; the count saturates so a lone
                    // streaming core is never cut off.
                    grant_vld_s = 1'b1;
                    grant_idx_s = owner_r;
                    if (burst_cnt_r < CNT_MAX) begin
                        burst_cnt_nxt_s = burst_cnt_r + CNT_ONE;
                    end else begin
                        burst_cnt_nxt_s = burst_cnt_r;
                    end
                end else if (|others_s) begin
                    // Hand over directly, no idle bubble on a switch.
                    grant_vld_s     = 1'b1;
                    grant_idx_s     = switch_pick_s[IDX_W-1:0];
                    owner_nxt_s     = switch_pick_s[IDX_W-1:0];
                    burst_cnt_nxt_s = CNT_ONE;
                end else begin
                    state_nxt_s  = ST_IDLE;
                    rr_ptr_nxt_s = idx_inc(owner_r);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Grant output: one-hot of the chosen core, forced low while in reset.
    always_comb begin
        gnt_s = '0;
        if (grant_vld_s && reset_n) begin
            gnt_s = idx_to_onehot(grant_idx_s);
        end else begin
            gnt_s = '0;
        end
    end

    // Mux the granted core's access fields onto the memory-port inputs.
    always_comb begin
        sel_oh_s    = idx_to_onehot(grant_idx_s);
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            sel_we_s    = sel_we_s    | (sel_oh_s[i] & we[i]);
            sel_addr_s  = sel_addr_s  | ({16{sel_oh_s[i]}} & addr[16*i +: 16]);
            sel_wdata_s = sel_wdata_s | ({32{sel_oh_s[i]}} & wdata[32*i +: 32]);
        end
    end

    // Memory port registers and the two-stage read tag pipeline.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_we_r         <= 1'b0;
            mem_addr_r       <= 16'h0000;
            mem_write_data_r <= 32'h0000_0000;
            tag1_r           <= '0;
            tag2_r           <= '0;
        end else begin
            tag2_r <= tag1_r;
            if (grant_vld_s) begin
                mem_we_r         <= sel_we_s;
                mem_addr_r       <= sel_addr_s;
                mem_write_data_r <= sel_wdata_s;
                tag1_r           <= sel_we_s ? '0 : sel_oh_s;
            end else begin
                // Idle cycle: suppress the write, keep the last address/data.
                mem_we_r         <= 1'b0;
                mem_addr_r       <= mem_addr_r;
                mem_write_data_r <= mem_write_data_r;
                tag1_r           <= '0;
            end
        end
    end

    assign gnt            = gnt_s;
    assign rvalid         = tag2_r;
    assign rdata          = mem_read_data;
    assign mem_we         = mem_we_r;
    assign mem_addr       = mem_addr_r;
    assign mem_write_data = mem_write_data_r;

endmodule

// File: tb/tb_sha256_mem_arbiter.sv
// Testbench for sha256_mem_arbiter: directed scenarios, a behavioural
// arbitration/memory model compared every cycle, and literal expectations.
module tb_sha256_mem_arbiter;

    localparam int NC   = 4;
    localparam int MAXB = 16;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [NC-1:0]  req;
    logic [NC-1:0]  we;
    logic [16*NC-1:0] addr;
    logic [32*NC-1:0] wdata;
    logic [NC-1:0]  gnt;
    logic [NC-1:0]  rvalid;
    logic [31:0]    rdata;
    logic           mem_we;
    logic [15:0]    mem_addr;
    logic [31:0]    mem_write_data;
    logic [31:0]    mem_read_data;

    sha256_mem_arbiter #(.NUM_CORES(NC), .MAX_BURST(MAXB)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .we             (we),
        .addr           (addr),
        .wdata          (wdata),
        .gnt            (gnt),
        .rvalid         (rvalid),
        .rdata          (rdata),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Initial memory contents: 0x10..0x13 hold 0xA0..0xA3, others a tagged pattern.
    function automatic logic [31:0] init_word(input logic [15:0] a);
        logic [31:0] w;
        if (a >= 16'h0010 && a <= 16'h0013) w = 32'h0000_00A0 + {16'h0000, a - 16'h0010};
        else w = {16'h5A5A, a};
        return w;
    endfunction

    // Memory device: one-cycle read latency, writes in order.
    logic [31:0] dev_mem [0:65535];
    bit          dev_wr  [0:65535];
    always @(posedge clk) begin
        if (mem_we) begin
            dev_mem[mem_addr] <= mem_write_data;
            dev_wr[mem_addr]  <= 1'b1;
        end
        mem_read_data <= dev_wr[mem_addr] ? dev_mem[mem_addr] : init_word(mem_addr);
    end

    // Bench-side state (touched only by the stimulus process).
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] sh_mem [0:65535];
    bit          sh_wr  [0:65535];

    int          m_owner = -1;
    int          m_run   = 0;
    int          m_ptr   = 0;
    bit          m_sync  = 1'b0;
    logic        e_we;
    logic [15:0] e_addr;
    logic [31:0] e_wd;
    logic [3:0]  e_tag1, e_tag2;
    logic [31:0] e_d1, e_d2;

    logic [3:0]  log_gnt   [0:1023];
    logic [3:0]  log_rv    [0:1023];
    logic        log_we    [0:1023];
    logic [15:0] log_addr  [0:1023];
    logic [31:0] log_wd    [0:1023];
    logic [31:0] log_rdata [0:1023];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", nm, cyc, act, exp_v);
        end
    endtask

    function automatic int scan(input logic [3:0] m, input int start);
        int c;
        for (int k = 0; k < NC; k++) begin
            c = (start + k) % NC;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    // One clock cycle: log and check outputs at negedge, advance the model,
    // then return just after the next posedge so new inputs can be driven.
    task automatic tick();
        int          g;
        logic [3:0]  others;
        logic [3:0]  eg;
        logic [15:0] a;
        @(negedge clk);
        log_gnt[cyc]   = gnt;
        log_rv[cyc]    = rvalid;
        log_we[cyc]    = mem_we;
        log_addr[cyc]  = mem_addr;
        log_wd[cyc]    = mem_write_data;
        log_rdata[cyc] = rdata;

        g = -1;
        if (reset_n) begin
            if (m_owner < 0) begin
                g = scan(req, m_ptr);
            end else begin
                others = req & ~(4'b0001 << m_owner);
                if (req[m_owner] && (m_run < MAXB || others == 4'b0000)) g = m_owner;
                else if (others != 4'b0000) g = scan(others, (m_owner + 1) % NC);
            end
        end
        eg = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk("model_gnt", {28'h0, gnt}, {28'h0, eg});
        if (m_sync) begin
            chk("model_mem_we", {31'h0, mem_we}, {31'h0, e_we});
            chk("model_mem_addr", {16'h0, mem_addr}, {16'h0, e_addr});
            chk("model_mem_wdata", mem_write_data, e_wd);
            chk("model_rvalid", {28'h0, rvalid}, {28'h0, e_tag2});
            if (e_tag2 != 4'b0000) chk("model_rdata", rdata, e_d2);
        end

        if (!reset_n) begin
            m_owner = -1; m_run = 0; m_ptr = 0; m_sync = 1'b1;
            e_we = 1'b0; e_addr = 16'h0; e_wd = 32'h0;
            e_tag1 = 4'b0; e_tag2 = 4'b0; e_d1 = 32'h0; e_d2 = 32'h0;
        end else begin
            e_tag2 = e_tag1;
            e_d2   = e_d1;
            if (g >= 0) begin
                a      = addr[16*g +: 16];
                e_we   = we[g];
                e_addr = a;
                e_wd   = wdata[32*g +: 32];
                if (we[g]) begin
                    sh_mem[a] = wdata[32*g +: 32];
                    sh_wr[a]  = 1'b1;
                    e_tag1    = 4'b0000;
                end else begin
                    e_tag1 = 4'b0001 << g;
                    e_d1   = sh_wr[a] ? sh_mem[a] : init_word(a);
                end
                if (g == m_owner) begin
                    if (m_run < MAXB) m_run++;
                end else begin
                    m_run = 1;
                end
                m_owner = g;
            end else begin
                e_we   = 1'b0;
                e_tag1 = 4'b0000;
                if (m_owner >= 0) begin
                    m_ptr   = (m_owner + 1) % NC;
                    m_owner = -1;
                    m_run   = 0;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    int t;
    int d;
    int r;

    initial begin
        reset_n = 1'b0;
        req = '0; we = '0; addr = '0; wdata = '0;
        tick(); tick();
        reset_n = 1'b1;

        // All four cores stream reads: 16 grants each in order 0,1,2,3.
        t = cyc;
        req = 4'b1111; we = 4'b0000;
        for (int i = 0; i < NC; i++) addr[16*i +: 16] = 16'h0040 + 16'(i);
        for (int k = 0; k < 64; k++) tick();
        req = 4'b0000;
        tick(); tick(); tick();
        for (int k = 0; k < 64; k++) begin
            chk("t2_gnt_order", {28'h0, log_gnt[t+k]}, 32'h1 << (k / 16));
            chk("t2_rvalid_tag", {28'h0, log_rv[t+2+k]}, 32'h1 << (k / 16));
            chk("t2_rdata", log_rdata[t+2+k], {16'h5A5A, 16'h0040 + 16'(k / 16)});
        end
        chk("t2_idle_after", {28'h0, log_gnt[t+64]}, 32'h0);

        // Core 0 alone reads 0x10..0x13.
        t = cyc;
        req = 4'b0001; we = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            addr[15:0] = 16'h0010 + 16'(k);
            tick();
        end
        req = 4'b0000;
        tick(); tick(); tick();
        for (int k = 0; k < 4; k++) begin
            chk("t1_gnt", {28'h0, log_gnt[t+k]}, 32'h1);
            chk("t1_mem_addr", {16'h0, log_addr[t+1+k]}, 32'h0010 + k);
            chk("t1_rvalid", {28'h0, log_rv[t+2+k]}, 32'h1);
            chk("t1_rdata", log_rdata[t+2+k], 32'h0000_00A0 + k);
        end
        chk("t1_rvalid_end", {28'h0, log_rv[t+6]}, 32'h0);

        // Core 2 writes 0xDEADBEEF to 0x0100, core 1 reads it back.
        t = cyc;
        req = 4'b0100; we = 4'b0100;
        addr[47:32] = 16'h0100; wdata[95:64] = 32'hDEAD_BEEF;
        tick();
        req = 4'b0010; we = 4'b0000; addr[31:16] = 16'h0100;
        tick();
        req = 4'b0000;
        tick(); tick(); tick();
        chk("t3_gnt_wr", {28'h0, log_gnt[t]}, 32'h4);
        chk("t3_gnt_rd", {28'h0, log_gnt[t+1]}, 32'h2);
        chk("t3_we_before", {31'h0, log_we[t]}, 32'h0);
        chk("t3_we_pulse", {31'h0, log_we[t+1]}, 32'h1);
        chk("t3_we_after", {31'h0, log_we[t+2]}, 32'h0);
        chk("t3_wdata", log_wd[t+1], 32'hDEAD_BEEF);
        chk("t3_addr", {16'h0, log_addr[t+1]}, 32'h0100);
        for (int k = 0; k < 5; k++) chk("t3_no_rvalid2", {31'h0, log_rv[t+k][2]}, 32'h0);
        chk("t3_rvalid1", {28'h0, log_rv[t+3]}, 32'h2);
        chk("t3_rdata", log_rdata[t+3], 32'hDEAD_BEEF);

        // Core 1 releases; then cores 0 and 2 request together.
        t = cyc;
        req = 4'b0010; addr[31:16] = 16'h0020;
        tick(); tick();
        d = cyc;
        req = 4'b0000;
        tick();
        req = 4'b0101; addr[15:0] = 16'h0030; addr[47:32] = 16'h0050;
        tick();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick(); tick(); tick();
        chk("t4_gnt_c1", {28'h0, log_gnt[t]}, 32'h2);
        chk("t4_gnt_c1b", {28'h0, log_gnt[t+1]}, 32'h2);
        chk("t4_gnt_idle", {28'h0, log_gnt[d]}, 32'h0);
        chk("t4_gnt_c2_first", {28'h0, log_gnt[d+1]}, 32'h4);
        chk("t4_gnt_c0_next", {28'h0, log_gnt[d+2]}, 32'h1);
        chk("t4_gnt_done", {28'h0, log_gnt[d+3]}, 32'h0);

        // Reset mid-burst with reads in flight.
        req = 4'b1111; we = 4'b0000;
        addr[63:48] = 16'h0060;
        for (int k = 0; k < 4; k++) tick();
        r = cyc;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        req = 4'b0000;
        tick(); tick(); tick(); tick();
        chk("t5_gnt_in_reset", {28'h0, log_gnt[r]}, 32'h0);
        chk("t5_rvalid_cleared", {28'h0, log_rv[r+1]}, 32'h0);
        chk("t5_we_cleared", {31'h0, log_we[r+1]}, 32'h0);
        chk("t5_addr_cleared", {16'h0, log_addr[r+1]}, 32'h0);
        chk("t5_gnt_c0_first", {28'h0, log_gnt[r+1]}, 32'h1);
        chk("t5_no_stale", {28'h0, log_rv[r+2]}, 32'h0);
        chk("t5_addr_new", {16'h0, log_addr[r+2]}, 32'h0030);
        chk("t5_rvalid_new", {28'h0, log_rv[r+3]}, 32'h1);
        chk("t5_rdata_new", log_rdata[r+3], 32'h5A5A_0030);
        chk("t5_rvalid_end", {28'h0, log_rv[r+4]}, 32'h0);

        // Ten idle cycles: outputs quiet, address holds.
        t = cyc;
        for (int k = 0; k < 10; k++) tick();
        for (int k = 0; k < 10; k++) begin
            chk("t6_gnt", {28'h0, log_gnt[t+k]}, 32'h0);
            chk("t6_we", {31'h0, log_we[t+k]}, 32'h0);
            chk("t6_rvalid", {28'h0, log_rv[t+k]}, 32'h0);
            chk("t6_addr_hold", {16'h0, log_addr[t+k]}, 32'h0030);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
